// File: rtl/pmem_line_responder.sv
// Line-organised backing store answering each 256-bit read/write with a one-cycle
// mem_resp pulse a fixed LATENCY cycles after acceptance; flags requester handshake violations.
module pmem_line_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [255:0] mem_wdata,
  output logic         mem_resp,
  output logic [255:0] mem_rdata,
  output logic         protocol_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LATENCY);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [31:0]     addr_q, addr_d;
  logic [255:0]    wdata_q, wdata_d;
  logic [255:0]    rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            busy_violation;

  logic [255:0]    mem_q [DEPTH];

  // Any drift of the held request while waiting counts as a handshake break.
  assign busy_violation = (wr_q ? !(mem_write && !mem_read) : !(mem_read && !mem_write))
                          || (mem_address != addr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_read ^ mem_write) begin
          wr_d    = mem_write;
          addr_d  = mem_address;
          wdata_d = mem_wdata;
          cnt_d   = CW'(1);
          state_d = (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end else if (mem_read && mem_write) begin
          err_d = 1'b1;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (busy_violation) err_d = 1'b1;
        if (cnt_d == LAT_C) state_d = ST_RESP;
      end
      ST_RESP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    // Read data is captured on the edge entering RESP so it is registered in the resp cycle.
    if (state_d == ST_RESP && state_q != ST_RESP && !wr_d) begin
      rdata_d = mem_q[addr_d[5 +: IW]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset; an async reset forces IDLE so no write can slip through.
  always_ff @(posedge clk) begin
    if (state_q == ST_RESP && wr_q) begin
      mem_q[addr_q[5 +: IW]] <= wdata_q;
    end
  end

  assign mem_resp     = (state_q == ST_RESP);
  assign mem_rdata    = rdata_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder: one instance at LATENCY=10, one at LATENCY=1.
module tb_pmem_line_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rd0, wr0, resp0, err0;
  logic [31:0]  addr0;
  logic [255:0] wd0, rdata0;
  logic         rd1, wr1, resp1, err1;
  logic [31:0]  addr1;
  logic [255:0] wd1, rdata1;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] DB = {8{32'hDEADBEEF}};
  localparam logic [255:0] D1 = {4{64'h0123_4567_89AB_CDEF}};

  always #5 clk = ~clk;

  pmem_line_responder #(.DEPTH(256), .LATENCY(10)) u0 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd0), .mem_write(wr0),
    .mem_address(addr0), .mem_wdata(wd0), .mem_resp(resp0),
    .mem_rdata(rdata0), .protocol_err(err0)
  );

  pmem_line_responder #(.DEPTH(256), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1),
    .mem_address(addr1), .mem_wdata(wd1), .mem_resp(resp1),
    .mem_rdata(rdata1), .protocol_err(err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the edge count (after the call) on which mem_resp is seen, or -1 if never.
  task automatic wait_resp(input bit sel, input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if ((sel ? resp1 : resp0) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (resp0 !== 1'b0) begin errors++; $display("FAIL reset_resp0 got %b exp 0", resp0); end
    checks++; if (rdata0 !== '0) begin errors++; $display("FAIL reset_rdata0 got %h exp 0", rdata0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err0 got %b exp 0", err0); end
    checks++; if (resp1 !== 1'b0) begin errors++; $display("FAIL reset_resp1 got %b exp 0", resp1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err1 got %b exp 0", err1); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    int lat;
    addr0 = 32'h0000_0040; wd0 = DB; wr0 = 1'b1;
    wait_resp(1'b0, 30, lat);
    wr0 = 1'b0;
    checks++; if (lat !== 10) begin errors++; $display("FAIL write_latency got %0d exp 10", lat); end
    tick();
    checks++; if (resp0 !== 1'b0) begin errors++; $display("FAIL write_resp_width got %b exp 0", resp0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL write_err got %b exp 0", err0); end
  endtask

  task automatic test_read();
    int lat;
    addr0 = 32'h0000_005C; rd0 = 1'b1;
    wait_resp(1'b0, 30, lat);
    rd0 = 1'b0;
    checks++; if (lat !== 10) begin errors++; $display("FAIL read_latency got %0d exp 10", lat); end
    checks++; if (rdata0 !== DB) begin errors++; $display("FAIL read_data got %h exp %h", rdata0, DB); end
    tick();
    checks++; if (rdata0 !== DB) begin errors++; $display("FAIL read_data_hold got %h exp %h", rdata0, DB); end
  endtask

  task automatic test_back_to_back();
    int lat;
    addr0 = 32'h0000_0100; wd0 = D1; wr0 = 1'b1;
    wait_resp(1'b0, 30, lat);
    wr0 = 1'b0;
    checks++; if (lat !== 10) begin errors++; $display("FAIL b2b_write_latency got %0d exp 10", lat); end
    checks++; if (rdata0 !== DB) begin errors++; $display("FAIL b2b_rdata_untouched got %h exp %h", rdata0, DB); end
    tick();
    checks++; if (resp0 !== 1'b0) begin errors++; $display("FAIL b2b_no_double_resp got %b exp 0", resp0); end
    rd0 = 1'b1;
    wait_resp(1'b0, 30, lat);
    rd0 = 1'b0;
    checks++; if (lat !== 10) begin errors++; $display("FAIL b2b_read_latency got %0d exp 10", lat); end
    checks++; if (rdata0 !== D1) begin errors++; $display("FAIL b2b_read_data got %h exp %h", rdata0, D1); end
    tick();
    checks++; if (resp0 !== 1'b0) begin errors++; $display("FAIL b2b_read_resp_width got %b exp 0", resp0); end
  endtask

  task automatic test_addr_change();
    int lat;
    addr0 = 32'h0000_0100; rd0 = 1'b1;
    repeat (3) tick();
    addr0 = 32'h0000_0040;
    wait_resp(1'b0, 30, lat);
    rd0 = 1'b0;
    checks++; if (lat !== 7) begin errors++; $display("FAIL addrchg_latency got %0d exp 7", lat); end
    checks++; if (rdata0 !== D1) begin errors++; $display("FAIL addrchg_data got %h exp %h", rdata0, D1); end
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL addrchg_err got %b exp 1", err0); end
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL err_cleared_by_reset got %b exp 0", err0); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_both_high();
    int lat;
    addr0 = 32'h0000_0200; rd0 = 1'b1; wr0 = 1'b1;
    wait_resp(1'b0, 20, lat);
    rd0 = 1'b0; wr0 = 1'b0;
    checks++; if (lat !== -1) begin errors++; $display("FAIL both_high_no_resp got %0d exp -1", lat); end
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL both_high_err got %b exp 1", err0); end
    tick();
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err0); end
  endtask

  task automatic test_reset_mid_write();
    int lat;
    int pulses;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    addr0 = 32'h0000_0100; wd0 = ~D1; wr0 = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0; wr0 = 1'b0;
    pulses = 0;
    repeat (3) begin tick(); if (resp0 === 1'b1) pulses++; end
    rst_n = 1'b1;
    repeat (12) begin tick(); if (resp0 === 1'b1) pulses++; end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_no_resp got %0d exp 0", pulses); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL rst_mid_err got %b exp 0", err0); end
    rd0 = 1'b1;
    wait_resp(1'b0, 30, lat);
    rd0 = 1'b0;
    checks++; if (lat !== 10) begin errors++; $display("FAIL rst_mid_read_latency got %0d exp 10", lat); end
    checks++; if (rdata0 !== D1) begin errors++; $display("FAIL rst_mid_old_data got %h exp %h", rdata0, D1); end
    tick();
  endtask

  task automatic test_latency1();
    int lat;
    addr1 = 32'h0000_0040; wd1 = DB; wr1 = 1'b1;
    wait_resp(1'b1, 5, lat);
    wr1 = 1'b0;
    checks++; if (lat !== 1) begin errors++; $display("FAIL lat1_write_latency got %0d exp 1", lat); end
    tick();
    checks++; if (resp1 !== 1'b0) begin errors++; $display("FAIL lat1_resp_width got %b exp 0", resp1); end
    rd1 = 1'b1;
    wait_resp(1'b1, 5, lat);
    rd1 = 1'b0;
    checks++; if (lat !== 1) begin errors++; $display("FAIL lat1_read_latency got %0d exp 1", lat); end
    checks++; if (rdata1 !== DB) begin errors++; $display("FAIL lat1_read_data got %h exp %h", rdata1, DB); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL lat1_err got %b exp 0", err1); end
  endtask

  initial begin
    rst_n = 1'b0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wd0 = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_addr_change();
    test_both_high();
    test_reset_mid_write();
    test_latency1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
